// File: rtl/nasti_stream_mux_pkg.sv
// rtl/nasti_stream_mux_pkg.sv - shared types and helpers for the NASTI-stream merge
package nasti_stream_pkg;

    localparam int MAX_STREAM_PORT = 4;

    typedef logic [1:0] port_idx_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Round-robin successor of idx among n active ports.
    function automatic port_idx_t next_port(input port_idx_t idx, input int n);
        int nx;
        nx = int'(idx) + 1;
        if (nx >= n) nx = 0;
        return port_idx_t'(nx);
    endfunction

endpackage

// File: rtl/nasti_stream_mux_if.sv
// rtl/nasti_stream_mux_if.sv - NASTI-stream channel interface with master/slave views
interface nasti_stream_channel #(
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1,
    parameter int DATA_WIDTH = 64
);
    logic                      t_valid;
    logic                      t_ready;
    logic [DATA_WIDTH-1:0]     t_data;
    logic [DATA_WIDTH/8-1:0]   t_strb;
    logic [DATA_WIDTH/8-1:0]   t_keep;
    logic                      t_last;
    logic [ID_WIDTH-1:0]       t_id;
    logic [DEST_WIDTH-1:0]     t_dest;
    logic [USER_WIDTH-1:0]     t_user;

    modport master (
        output t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
        input  t_ready
    );

    modport slave (
        input  t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
        output t_ready
    );
endinterface

// File: rtl/nasti_stream_mux_arbiter.sv
// rtl/nasti_stream_mux_arbiter.sv - combinational round-robin pick starting at ptr
module nasti_stream_rr_arbiter
    import nasti_stream_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  port_idx_t    ptr,
    output logic [N-1:0] grant_onehot,
    output port_idx_t    grant_idx,
    output logic         grant_valid
);
    logic [MAX_STREAM_PORT-1:0] req_pad;
    port_idx_t                  idx;
    int                         k;

    assign req_pad = MAX_STREAM_PORT'(req);

    always_comb begin
        grant_idx   = ptr;
        grant_valid = 1'b0;
        idx         = '0;
        k           = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) k = k - N;
            idx = port_idx_t'(k);
            if (!grant_valid && req_pad[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_onehot
        assign grant_onehot[j] = grant_valid && (grant_idx == port_idx_t'(j));
    end

endmodule

// File: rtl/nasti_stream_mux.sv
// rtl/nasti_stream_mux.sv - packet-atomic round-robin N:1 merge with registered output
module nasti_stream_mux
    import nasti_stream_pkg::*;
#(
    parameter int N_PORT     = 1,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1,
    parameter int DATA_WIDTH = 64,
    parameter int TAG_ID     = 0
) (
    input  logic                clk,
    input  logic                rstn,
    nasti_stream_channel.slave  in_0,
    nasti_stream_channel.slave  in_1,
    nasti_stream_channel.slave  in_2,
    nasti_stream_channel.slave  in_3,
    nasti_stream_channel.master out
);
    localparam int SW     = DATA_WIDTH / 8;
    localparam int O_DEST = USER_WIDTH;
    localparam int O_ID   = O_DEST + DEST_WIDTH;
    localparam int O_LAST = O_ID + ID_WIDTH;
    localparam int O_KEEP = O_LAST + 1;
    localparam int O_STRB = O_KEEP + SW;
    localparam int O_DATA = O_STRB + SW;
    localparam int PW     = O_DATA + DATA_WIDTH;

    if (N_PORT < 1 || N_PORT > MAX_STREAM_PORT) begin : g_bad_nport
        $error("nasti_stream_mux: N_PORT must be 1..4");
    end
    if (TAG_ID != 0 && (2 ** ID_WIDTH) < N_PORT) begin : g_bad_tag
        $error("nasti_stream_mux: ID_WIDTH too narrow to tag source port");
    end

    logic [MAX_STREAM_PORT-1:0] in_valid;
    logic [MAX_STREAM_PORT-1:0] in_ready;
    logic [PW-1:0]              in_pay [MAX_STREAM_PORT];

    // Payload packed as {data, strb, keep, last, id, dest, user}.
    assign in_valid  = {in_3.t_valid, in_2.t_valid, in_1.t_valid, in_0.t_valid};
    assign in_pay[0] = {in_0.t_data, in_0.t_strb, in_0.t_keep, in_0.t_last, in_0.t_id, in_0.t_dest, in_0.t_user};
    assign in_pay[1] = {in_1.t_data, in_1.t_strb, in_1.t_keep, in_1.t_last, in_1.t_id, in_1.t_dest, in_1.t_user};
    assign in_pay[2] = {in_2.t_data, in_2.t_strb, in_2.t_keep, in_2.t_last, in_2.t_id, in_2.t_dest, in_2.t_user};
    assign in_pay[3] = {in_3.t_data, in_3.t_strb, in_3.t_keep, in_3.t_last, in_3.t_id, in_3.t_dest, in_3.t_user};
    assign in_0.t_ready = in_ready[0];
    assign in_1.t_ready = in_ready[1];
    assign in_2.t_ready = in_ready[2];
    assign in_3.t_ready = in_ready[3];

    arb_state_t         state;
    port_idx_t          ptr;
    port_idx_t          grant;
    port_idx_t          sel;
    port_idx_t          arb_idx;
    logic               arb_valid;
    logic [N_PORT-1:0]  arb_onehot;
    logic               sel_ok;
    logic               can_load;
    logic               accept;
    logic               ld_last;
    logic [PW-1:0]      ld_pay;
    logic               out_valid_q;
    logic [PW-1:0]      out_pay_q;

    nasti_stream_rr_arbiter #(.N(N_PORT)) u_arb (
        .req          (in_valid[N_PORT-1:0]),
        .ptr          (ptr),
        .grant_onehot (arb_onehot),
        .grant_idx    (arb_idx),
        .grant_valid  (arb_valid)
    );

    assign can_load = !out_valid_q || out.t_ready;

    always_comb begin
        sel    = (state == LOCKED) ? grant : arb_idx;
        sel_ok = (state == LOCKED) || arb_valid;
        ld_pay = in_pay[sel];
        if (TAG_ID != 0) ld_pay[O_ID +: ID_WIDTH] = ID_WIDTH'(sel);
        ld_last = ld_pay[O_LAST];
        accept  = can_load && sel_ok && in_valid[sel];
    end

    // While locked the granted port keeps ready even when its valid drops.
    for (genvar k = 0; k < MAX_STREAM_PORT; k++) begin : g_ready
        if (k < N_PORT) begin : g_act
            assign in_ready[k] = rstn && can_load &&
                ((state == LOCKED) ? (grant == port_idx_t'(k)) : arb_onehot[k]);
        end else begin : g_off
            assign in_ready[k] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            out_pay_q   <= '0;
            state       <= IDLE;
            grant       <= '0;
            ptr         <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_pay_q   <= ld_pay;
            if (ld_last) begin
                state <= IDLE;
                ptr   <= next_port(sel, N_PORT);
            end else begin
                state <= LOCKED;
                grant <= sel;
            end
        end else if (out.t_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out.t_valid = out_valid_q;
    assign out.t_data  = out_pay_q[O_DATA +: DATA_WIDTH];
    assign out.t_strb  = out_pay_q[O_STRB +: SW];
    assign out.t_keep  = out_pay_q[O_KEEP +: SW];
    assign out.t_last  = out_pay_q[O_LAST];
    assign out.t_id    = out_pay_q[O_ID +: ID_WIDTH];
    assign out.t_dest  = out_pay_q[O_DEST +: DEST_WIDTH];
    assign out.t_user  = out_pay_q[0 +: USER_WIDTH];

endmodule

// File: tb/tb_nasti_stream_mux.sv
// tb/tb_nasti_stream_mux.sv - randomized bench for nasti_stream_mux against a packet-level model
module tb_nasti_stream_mux;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  keep;
        logic        last;
        logic [1:0]  id;
        logic [1:0]  dest;
        logic [1:0]  user;
    } beat_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    nasti_stream_channel #(.ID_WIDTH(2), .DEST_WIDTH(2), .USER_WIDTH(2), .DATA_WIDTH(32)) in0 ();
    nasti_stream_channel #(.ID_WIDTH(2), .DEST_WIDTH(2), .USER_WIDTH(2), .DATA_WIDTH(32)) in1 ();
    nasti_stream_channel #(.ID_WIDTH(2), .DEST_WIDTH(2), .USER_WIDTH(2), .DATA_WIDTH(32)) in2 ();
    nasti_stream_channel #(.ID_WIDTH(2), .DEST_WIDTH(2), .USER_WIDTH(2), .DATA_WIDTH(32)) in3 ();
    nasti_stream_channel #(.ID_WIDTH(2), .DEST_WIDTH(2), .USER_WIDTH(2), .DATA_WIDTH(32)) out_ch ();

    logic [3:0] v = '0;
    logic [3:0] rdy;
    beat_t      drv [4];
    beat_t      o_beat;
    logic       o_ready = 1'b0;

    assign in0.t_valid = v[0];
    assign in1.t_valid = v[1];
    assign in2.t_valid = v[2];
    assign in3.t_valid = v[3];
    assign {in0.t_data, in0.t_strb, in0.t_keep, in0.t_last, in0.t_id, in0.t_dest, in0.t_user} = drv[0];
    assign {in1.t_data, in1.t_strb, in1.t_keep, in1.t_last, in1.t_id, in1.t_dest, in1.t_user} = drv[1];
    assign {in2.t_data, in2.t_strb, in2.t_keep, in2.t_last, in2.t_id, in2.t_dest, in2.t_user} = drv[2];
    assign {in3.t_data, in3.t_strb, in3.t_keep, in3.t_last, in3.t_id, in3.t_dest, in3.t_user} = drv[3];
    assign rdy = {in3.t_ready, in2.t_ready, in1.t_ready, in0.t_ready};
    assign o_beat = {out_ch.t_data, out_ch.t_strb, out_ch.t_keep, out_ch.t_last,
                     out_ch.t_id, out_ch.t_dest, out_ch.t_user};
    assign out_ch.t_ready = o_ready;

    nasti_stream_mux #(
        .N_PORT(4), .ID_WIDTH(2), .DEST_WIDTH(2), .USER_WIDTH(2), .DATA_WIDTH(32), .TAG_ID(1)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .in_0 (in0),
        .in_1 (in1),
        .in_2 (in2),
        .in_3 (in3),
        .out  (out_ch)
    );

    int checks = 0;
    int errors = 0;

    // Source side: per-port pending beats, and whether the head is currently offered.
    beat_t      q [4][$];
    bit         held [4];
    logic [3:0] mute = '0;
    int         gap_pct = 0;
    int         ordy_pct = 100;
    bit         stall = 1'b0;

    // Reference: owner of the output (-1 none), next round-robin start, output register.
    int    m_owner = -1;
    int    m_rr = 0;
    bit    m_ov = 1'b0;
    beat_t m_out;

    int dut_order [$];
    int cur_src = -1;
    int out_beats = 0;

    task automatic add_pkt(input int k, input int len, input int fid);
        for (int i = 0; i < len; i++) begin
            beat_t b;
            b.data = $urandom;
            b.strb = 4'($urandom);
            b.keep = 4'($urandom);
            b.last = (i == len - 1);
            b.id   = (fid < 0) ? 2'($urandom) : 2'(fid);
            b.dest = 2'($urandom);
            b.user = 2'($urandom);
            q[k].push_back(b);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            if (!held[k] && !mute[k] && q[k].size() > 0 && $urandom_range(99) >= gap_pct)
                held[k] = 1'b1;
            v[k]   = held[k];
            drv[k] = held[k] ? q[k][0] : beat_t'({$urandom, $urandom});
        end
        o_ready = stall ? 1'b0 : ($urandom_range(99) < ordy_pct);
    endtask

    function automatic bit busy();
        for (int k = 0; k < 4; k++) if (q[k].size() > 0 || held[k]) return 1'b1;
        return m_ov;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_rr = 0;
        m_ov = 1'b0;
        cur_src = -1;
        for (int k = 0; k < 4; k++) begin
            q[k].delete();
            held[k] = 1'b0;
        end
    endtask

    // One clock: offer inputs, check readies, advance the model, check the output register.
    task automatic step();
        int         sel;
        bit         can;
        bit         acc;
        logic [3:0] exp_rdy;
        beat_t      b;
        drive();
        #1;
        can = !m_ov || o_ready;
        sel = -1;
        if (m_owner >= 0) sel = m_owner;
        else for (int i = 0; i < 4; i++) if (sel < 0 && v[(m_rr + i) % 4]) sel = (m_rr + i) % 4;
        exp_rdy = '0;
        if (can && sel >= 0) exp_rdy[sel] = 1'b1;
        checks++;
        if (rdy !== exp_rdy) begin
            errors++;
            $display("FAIL ready @%0t: got %b want %b", $time, rdy, exp_rdy);
        end
        acc = can && sel >= 0 && v[sel];
        if (out_ch.t_valid && o_ready) begin
            out_beats++;
            if (cur_src >= 0) begin
                checks++;
                if (int'(o_beat.id) != cur_src) begin
                    errors++;
                    $display("FAIL interleave @%0t: got src %0d want %0d", $time, o_beat.id, cur_src);
                end
            end
            cur_src = o_beat.last ? -1 : int'(o_beat.id);
            if (o_beat.last) dut_order.push_back(int'(o_beat.id));
        end
        @(posedge clk);
        if (acc) begin
            b = q[sel].pop_front();
            held[sel] = 1'b0;
            b.id = 2'(sel);
            m_out = b;
            m_ov = 1'b1;
            if (b.last) begin
                m_owner = -1;
                m_rr = (sel + 1) % 4;
            end else begin
                m_owner = sel;
            end
        end else if (o_ready) begin
            m_ov = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (out_ch.t_valid !== m_ov) begin
            errors++;
            $display("FAIL out_valid @%0t: got %b want %b", $time, out_ch.t_valid, m_ov);
        end
        if (m_ov) begin
            checks++;
            if (o_beat !== m_out) begin
                errors++;
                $display("FAIL out_beat @%0t: got %h want %h", $time, o_beat, m_out);
            end
        end
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (busy() && n < max) begin
            step();
            n++;
        end
        checks++;
        if (busy()) begin
            errors++;
            $display("FAIL drain_timeout: still busy after %0d cycles, want idle", max);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        model_reset();
        v = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        v = 4'hF;
        for (int k = 0; k < 4; k++) drv[k] = beat_t'({$urandom, $urandom});
        o_ready = 1'b1;
        #1;
        checks++;
        if (rdy !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", rdy); end
        checks++;
        if (out_ch.t_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_ch.t_valid); end
        checks++;
        if (o_beat !== '0) begin errors++; $display("FAIL reset_payload: got %h want 0", o_beat); end
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_single_port();
        int b0 = out_beats;
        gap_pct = 0; ordy_pct = 100;
        add_pkt(2, 3, -1);
        drain(50);
        repeat (2) step();
        checks++;
        if (out_beats - b0 != 3) begin errors++; $display("FAIL single_beats: got %0d want 3", out_beats - b0); end
        checks++;
        if (dut_order[$] != 2) begin errors++; $display("FAIL single_src: got %0d want 2", dut_order[$]); end
    endtask

    task automatic test_fairness();
        int base;
        int exp_ord [5] = '{0, 1, 2, 3, 0};
        do_reset();
        base = dut_order.size();
        for (int r = 0; r < 2; r++) for (int k = 0; k < 4; k++) add_pkt(k, 2, -1);
        drain(100);
        repeat (2) step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (base + i >= dut_order.size() || dut_order[base + i] != exp_ord[i]) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %0d want %0d", i,
                         (base + i < dut_order.size()) ? dut_order[base + i] : -1, exp_ord[i]);
            end
        end
    endtask

    task automatic test_lock_hold();
        int base = dut_order.size();
        mute = 4'b1000;
        add_pkt(1, 4, -1);
        add_pkt(3, 2, -1);
        for (int n = 0; n < 20 && q[1].size() > 3; n++) step();
        mute = 4'b0000;
        for (int n = 0; n < 20 && q[1].size() > 2; n++) step();
        mute = 4'b0010;
        repeat (2) begin
            step();
            checks++;
            if (rdy[3] !== 1'b0) begin errors++; $display("FAIL lock_in3_ready: got %b want 0", rdy[3]); end
        end
        mute = 4'b0000;
        drain(60);
        repeat (2) step();
        checks++;
        if (dut_order.size() < base + 2 || dut_order[base] != 1 || dut_order[base + 1] != 3) begin
            errors++;
            $display("FAIL lock_order: got %0d entries want order 1,3", dut_order.size() - base);
        end
    endtask

    task automatic test_backpressure();
        beat_t snap;
        for (int k = 0; k < 4; k++) repeat (2) add_pkt(k, $urandom_range(1, 3), -1);
        repeat (3) step();
        snap = o_beat;
        stall = 1'b1;
        repeat (5) step();
        checks++;
        if (out_ch.t_valid !== 1'b1 || o_beat !== snap) begin
            errors++;
            $display("FAIL stall_hold: got %b/%h want 1/%h", out_ch.t_valid, o_beat, snap);
        end
        stall = 1'b0;
        drain(200);
    endtask

    task automatic test_tag();
        int n = 0;
        add_pkt(3, 2, 0);
        while (!out_ch.t_valid && n < 20) begin step(); n++; end
        checks++;
        if (out_ch.t_valid !== 1'b1 || o_beat.id !== 2'd3) begin
            errors++;
            $display("FAIL tag_id: got valid %b id %0d want 1/3", out_ch.t_valid, o_beat.id);
        end
        drain(50);
    endtask

    task automatic test_random();
        gap_pct = 30; ordy_pct = 70;
        for (int k = 0; k < 4; k++) repeat (5) add_pkt(k, $urandom_range(1, 4), -1);
        drain(2000);
        gap_pct = 0; ordy_pct = 100;
    endtask

    task automatic test_reset_mid();
        add_pkt(0, 4, -1);
        for (int n = 0; n < 20 && q[0].size() > 2; n++) step();
        #3;
        rstn = 1'b0;
        #1;
        checks++;
        if (out_ch.t_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b want 0", out_ch.t_valid); end
        checks++;
        if (rdy !== 4'b0000) begin errors++; $display("FAIL midreset_ready: got %b want 0000", rdy); end
        model_reset();
        v = '0;
        @(negedge clk);
        rstn = 1'b1;
        add_pkt(2, 2, -1);
        drain(50);
        repeat (2) step();
        checks++;
        if (dut_order[$] != 2) begin errors++; $display("FAIL midreset_src: got %0d want 2", dut_order[$]); end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) held[k] = 1'b0;
        test_reset();
        test_single_port();
        test_fairness();
        test_lock_hold();
        test_backpressure();
        test_tag();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
